uart_tx_serializer: RTL and testbench

- UART transmit serializer: accepts a parallel byte with a one-cycle start strobe and drives a framed serial line (start, data LSB-first, optional parity, stop).
- Sits directly upstream of the receive top. Its tx and busy outputs connect one-to-one to the receiver's tx and busy inputs, so benches can drive real frames instead of hand-written bit patterns.

---
 rtl/uart_tx_serializer.sv | 145 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              bit_end;

    assign bit_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    shift_d = tx_data;
                    bit_d   = '0;
                    div_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames,
// a negedge monitor rebuilds each frame from the serial line and checks it.
module tb_uart_tx_serializer;
    localparam int C  = 4;
    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx, busy, tx_done;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int done_cnt = 0;
    int d0, f0, n;

    logic [NB-1:0] sb_q[$];
    logic [NB-1:0] got;
    logic [NB-1:0] exp_f;
    logic          in_frame = 1'b0;
    logic          busy_prev = 1'b0;
    logic          bad = 1'b0;
    int            mcyc = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx(tx),
        .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic par);
`ifdef UART_TX_PARITY_EN
        sb_q.push_back({1'b1, par, d, 1'b0});
`else
        sb_q.push_back({1'b1, d, 1'b0});
`endif
    endtask

    // Monitor: rebuild each frame one bit per C cycles
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && busy && !busy_prev) begin
                in_frame = 1'b1;
                mcyc = 0;
                bad = 1'b0;
                got = '0;
                frames_seen++;
            end
            if (in_frame) begin
                if (mcyc < NB * C) begin
                    if (mcyc % C == 0) got[mcyc / C] = tx;
                    else if (tx !== got[mcyc / C]) bad = 1'b1;
                    if (busy !== 1'b1 || tx_done !== 1'b0) bad = 1'b1;
                    mcyc++;
                end else begin
                    chk("frame_end", {29'd0, busy, tx_done, tx}, 32'h3);
                    chk("bit_stable", {31'd0, bad}, 32'h0);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got frame %0h expected none", got);
                    end else begin
                        exp_f = sb_q.pop_front();
                        chk("frame_bits", 32'(got), 32'(exp_f));
                    end
                    in_frame = 1'b0;
                end
            end
        end
        busy_prev = busy;
    end

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt++;
            chk("done_busy_excl", {31'd0, busy}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while ((busy !== 1'b0 || in_frame || sb_q.size() != 0) && k < maxc) begin
            tick();
            k++;
        end
        chk("idle_wait", {31'd0, k < maxc}, 32'h1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic par,
                        input bit exp_en);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            tick();
            k++;
        end
        if (exp_en) push(d, par);
        tx_start = 1'b1;
        tx_data = d;
        tick();
        tx_start = 1'b0;
        chk("accept", {30'd0, busy, tx}, 32'h2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with tx_start held high
        #1;
        rst = 1'b1;
        tx_start = 1'b1;
        tx_data = 8'hA5;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outs", {29'd0, tx, busy, tx_done}, 32'h4);
        end
        @(negedge clk);
        tx_start = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_reset_idle", {29'd0, tx, busy, tx_done}, 32'h4);
        chk("reset_no_frame", frames_seen, 0);

        // Single frame
        d0 = done_cnt;
        send(8'hA5, 1'b0, 1'b1);
        wait_idle(100);
        chk("single_done_cnt", done_cnt - d0, 1);

        // Start request mid-frame is ignored
        d0 = done_cnt;
        f0 = frames_seen;
        send(8'hA5, 1'b0, 1'b1);
        repeat (11) tick();
        tx_start = 1'b1;
        tx_data = 8'hFF;
        tick();
        tx_start = 1'b0;
        wait_idle(100);
        repeat (10) tick();
        chk("ignored_frames", frames_seen - f0, 1);
        chk("ignored_done", done_cnt - d0, 1);
        chk("ignored_idle", {31'd0, busy}, 32'h0);

        // Back-to-back with tx_start held high
        f0 = frames_seen;
        push(8'h00, 1'b0);
        tx_data = 8'h00;
        tx_start = 1'b1;
        tick();
        chk("b2b_accept1", {30'd0, busy, tx}, 32'h2);
        push(8'hFF, 1'b0);
        tx_data = 8'hFF;
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_done_seen", {31'd0, tx_done}, 32'h1);
        chk("b2b_gap_busy", {31'd0, busy}, 32'h0);
        tick();
        chk("b2b_second_start", {30'd0, busy, tx}, 32'h2);
        tx_start = 1'b0;
        wait_idle(100);
        chk("b2b_frames", frames_seen - f0, 2);

        // Reset in cycle 18 of a frame
        d0 = done_cnt;
        send(8'h3C, 1'b0, 1'b0);
        repeat (17) tick();
        rst = 1'b1;
        #1;
        chk("midrst_async", {29'd0, tx, busy, tx_done}, 32'h4);
        tick();
        chk("midrst_hold", {29'd0, tx, busy, tx_done}, 32'h4);
        rst = 1'b0;
        repeat (5) tick();
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", {30'd0, tx, busy}, 32'h2);
        send(8'h81, 1'b0, 1'b1);
        wait_idle(100);

        // Parity vectors (plain frames when parity is disabled)
        send(8'h07, 1'b1, 1'b1);
        wait_idle(100);
        send(8'h03, 1'b0, 1'b1);
        wait_idle(100);

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
